// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch (IF)
// and data load/store (D); each access runs issue -> wait -> capture -> ack.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_reg, state_next;
    logic                owner_d_reg;
    logic                we_reg;
    logic [3:0]          cnt_reg;
    logic [3:0]          starve_reg;
    logic                kill_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;

    logic grant_d, grant_if, kill_now, kill_eff;

    // IF is forced only when it has waited out STARVE_MAX D grants; a redirect blocks it.
    assign grant_d  = d_req && !(if_req && (starve_reg == STARVE_LIM));
    assign grant_if = !grant_d && if_req && !if_kill;

    // A kill seen in the current cycle counts immediately so a late redirect still
    // suppresses the capture and the ack of the fetch it cancels.
    assign kill_now = !owner_d_reg && (state_reg != IDLE) && if_kill;
    assign kill_eff = kill_reg || kill_now;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (grant_d || grant_if) state_next = ISSUE;
            ISSUE: state_next = we_reg ? DONE : WAIT;
            WAIT:  if (cnt_reg == 4'd0) state_next = DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_d_reg   <= 1'b0;
            we_reg        <= 1'b0;
            cnt_reg       <= 4'd0;
            starve_reg    <= 4'd0;
            kill_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        owner_d_reg   <= 1'b1;
                        we_reg        <= d_we;
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        if (!if_req)
                            starve_reg <= 4'd0;
                        else if (starve_reg != STARVE_LIM)
                            starve_reg <= starve_reg + 4'd1;
                    end else if (grant_if) begin
                        owner_d_reg  <= 1'b0;
                        we_reg       <= 1'b0;
                        mem_addr_reg <= if_addr;
                        starve_reg   <= 4'd0;
                    end
                end
                ISSUE: cnt_reg <= LAT_LAST;
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        if (owner_d_reg)
                            d_rdata_reg <= mem_rdata;
                        else if (!kill_eff)
                            if_rdata_reg <= mem_rdata;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: ;
            endcase
            if (state_reg == DONE)
                kill_reg <= 1'b0;
            else if (kill_now)
                kill_reg <= 1'b1;
        end
    end

    assign mem_cs    = (state_reg == ISSUE);
    assign mem_we    = (state_reg == ISSUE) && we_reg;
    assign busy      = (state_reg != IDLE);
    assign d_ack     = (state_reg == DONE) && owner_d_reg;
    assign if_ack    = (state_reg == DONE) && !owner_d_reg && !kill_eff;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model
// and a behavioural memory that returns a known word exactly MEM_LAT cycles after a read.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_cs, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Behavioural memory: valid word only in the cycle MEM_LAT after the read strobe.
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         wr_log[$];
    int          rd_issue = -100;
    logic [31:0] rd_addr  = '0;

    always @(negedge clk) begin
        if (rd_issue + LAT == cyc) mem_rdata = mem_word(rd_addr);
        else                       mem_rdata = $urandom;
        if (mem_cs === 1'b1) begin
            if (mem_we) wr_log.push_back('{mem_addr, mem_wdata});
            else begin rd_issue = cyc; rd_addr = mem_addr; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Steps from an IDLE cycle with requests driven; lat = cycles until the ack pulse.
    task automatic wait_ack(output int lat, output logic got_if, output logic got_d);
        lat = -1; got_if = 1'b0; got_d = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (if_ack || d_ack) begin
                lat = n; got_if = if_ack; got_d = d_ack;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; d_req = 1'b1; d_addr = 32'h44;
        tick(); tick();
        checks++; if ({if_ack, d_ack, mem_cs, mem_we, busy} !== 5'b0)
            $display("FAIL reset_ctrl got=%b want=00000", {if_ack, d_ack, mem_cs, mem_we, busy}); else passed++;
        checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0)
            $display("FAIL reset_regs got=%h want=0", {mem_addr, mem_wdata, if_rdata, d_rdata}); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_hold busy=%b want=0", busy); else passed++;
        d_req = 1'b0; reset = 1'b0;
    endtask

    task automatic test_fetch();
        int lat; logic gi, gd;
        if_req = 1'b1; if_addr = 32'h0040_0000;
        tick();
        checks++; if ({mem_cs, mem_we, mem_addr} !== {2'b10, 32'h0040_0000})
            $display("FAIL fetch_issue got=%b/%h want=10/00400000", {mem_cs, mem_we}, mem_addr); else passed++;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gi, gd} !== {1 + LAT, 2'b10})
            $display("FAIL fetch_ack lat=%0d if=%b d=%b want lat=%0d if=1 d=0", lat, gi, gd, 1 + LAT); else passed++;
        checks++; if (if_rdata !== mem_word(32'h0040_0000))
            $display("FAIL fetch_data got=%h want=%h", if_rdata, mem_word(32'h0040_0000)); else passed++;
        $display("txn fetch addr=00400000 lat=%0d data=%h", lat + 1, if_rdata);
        if_req = 1'b0;
        tick();
        checks++; if ({if_ack, busy} !== 2'b00) $display("FAIL fetch_idle got=%b want=00", {if_ack, busy}); else passed++;
    endtask

    task automatic test_store();
        int lat; logic gi, gd;
        wr_log.delete();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        tick();
        checks++; if ({mem_cs, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h10, 32'hDEADBEEF})
            $display("FAIL store_issue got=%b/%h/%h want=11/00000010/deadbeef", {mem_cs, mem_we}, mem_addr, mem_wdata); else passed++;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gi, gd} !== {32'd1, 2'b01})
            $display("FAIL store_ack lat=%0d if=%b d=%b want lat=1 if=0 d=1", lat, gi, gd); else passed++;
        checks++; if (wr_log.size() != 1)
            $display("FAIL store_count got=%0d want=1", wr_log.size()); else passed++;
        $display("txn store addr=00000010 data=deadbeef lat=%0d", lat + 1);
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        int lat; logic gi, gd;
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gi, gd} !== {2 + LAT, 2'b01})
            $display("FAIL conflict_d lat=%0d if=%b d=%b want lat=%0d if=0 d=1", lat, gi, gd, 2 + LAT); else passed++;
        checks++; if (d_rdata !== mem_word(32'h200))
            $display("FAIL conflict_d_data got=%h want=%h", d_rdata, mem_word(32'h200)); else passed++;
        $display("txn load addr=00000200 lat=%0d data=%h", lat, d_rdata);
        d_req = 1'b0;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gi, gd} !== {3 + LAT, 2'b10})
            $display("FAIL conflict_if gap=%0d if=%b d=%b want gap=%0d if=1 d=0", lat, gi, gd, 3 + LAT); else passed++;
        checks++; if (if_rdata !== mem_word(32'h400))
            $display("FAIL conflict_if_data got=%h want=%h", if_rdata, mem_word(32'h400)); else passed++;
        $display("txn fetch addr=00000400 gap=%0d data=%h", lat, if_rdata);
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int lat, waited; logic gi, gd, want_d; logic [31:0] a;
        do_reset();
        waited = 0;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int r = 0; r < 10; r++) begin
            if (!d_req) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1, 0)); d_addr = $urandom; d_wdata = $urandom;
            end
            want_d = (waited < SMAX);
            waited = want_d ? waited + 1 : 0;
            a = want_d ? d_addr : if_addr;
            wait_ack(lat, gi, gd);
            checks++; if ({gi, gd} !== {!want_d, want_d})
                $display("FAIL starve_owner round=%0d if=%b d=%b want d=%b", r, gi, gd, want_d); else passed++;
            $display("txn starve round=%0d owner=%s addr=%h lat=%0d", r, gd ? "D" : "IF", a, lat);
            if (gd) d_req = 1'b0;
            else if_addr = if_addr + 32'd4;
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_kill();
        int lat, seen; logic gi, gd; logic [31:0] prev;
        prev = if_rdata;
        if_req = 1'b1; if_addr = 32'h2000;
        tick(); tick(); tick();
        if_kill = 1'b1; if_req = 1'b0;
        tick();
        if_kill = 1'b0;
        checks++; if ({if_ack, if_rdata} !== {1'b0, prev})
            $display("FAIL kill_late ack=%b data=%h want ack=0 data=%h", if_ack, if_rdata, prev); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL kill_late_busy got=%b want=0", busy); else passed++;
        $display("txn fetch addr=00002000 killed in last wait");

        if_req = 1'b1; if_addr = 32'h3000;
        tick();
        if_kill = 1'b1; if_req = 1'b0;
        tick();
        if_kill = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin tick(); if (if_ack) seen++; end
        checks++; if ({seen, if_rdata, busy} !== {32'd0, prev, 1'b0})
            $display("FAIL kill_early acks=%0d data=%h busy=%b want 0/%h/0", seen, if_rdata, busy, prev); else passed++;
        $display("txn fetch addr=00003000 killed in issue");

        if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h5000;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL kill_idle_block busy=%b want=0", busy); else passed++;
        if_kill = 1'b0;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gi, if_rdata} !== {2 + LAT, 1'b1, mem_word(32'h5000)})
            $display("FAIL kill_recover lat=%0d if=%b data=%h want %0d/1/%h", lat, gi, if_rdata, 2 + LAT, mem_word(32'h5000)); else passed++;
        $display("txn fetch addr=00005000 lat=%0d data=%h", lat, if_rdata);
        if_req = 1'b0;
        tick();

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
        tick();
        if_kill = 1'b1;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gd, d_rdata} !== {1 + LAT, 1'b1, mem_word(32'h6000)})
            $display("FAIL kill_no_d_effect lat=%0d d=%b data=%h want %0d/1/%h", lat, gd, d_rdata, 1 + LAT, mem_word(32'h6000)); else passed++;
        $display("txn load addr=00006000 with if_kill data=%h", d_rdata);
        if_kill = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; logic gi, gd;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7000;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({if_ack, d_ack, mem_cs, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata} !== 133'b0)
            $display("FAIL reset_mid got ctrl=%b d_rdata=%h want all zero", {if_ack, d_ack, mem_cs, mem_we, busy}, d_rdata); else passed++;
        wait_ack(lat, gi, gd);
        checks++; if ({lat, gd, d_rdata} !== {2 + LAT, 1'b1, mem_word(32'h7000)})
            $display("FAIL reset_reissue lat=%0d d=%b data=%h want %0d/1/%h", lat, gd, d_rdata, 2 + LAT, mem_word(32'h7000)); else passed++;
        $display("txn load addr=00007000 reissued after reset lat=%0d", lat);
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int lat, streak, want_lat; logic gi, gd, if_p, d_p, want_d; logic [31:0] want_data;
        do_reset();
        streak = 0; if_p = 1'b0; d_p = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (!if_p && $urandom_range(1, 0) == 1) begin
                if_p = 1'b1; if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_p && ($urandom_range(1, 0) == 1 || !if_p)) begin
                d_p = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(1, 0));
                d_addr = $urandom; d_wdata = $urandom;
            end
            // D wins unless IF has already watched SMAX consecutive D grants.
            want_d = d_p && !(if_p && streak == SMAX);
            if (want_d) streak = if_p ? ((streak == SMAX) ? SMAX : streak + 1) : 0;
            else        streak = 0;
            want_lat  = (want_d && d_we) ? 2 : 2 + LAT;
            want_data = !want_d ? mem_word(if_addr) : (d_we ? d_wdata : mem_word(d_addr));
            wr_log.delete();
            wait_ack(lat, gi, gd);
            checks++; if ({lat, gi, gd} !== {want_lat, !want_d, want_d})
                $display("FAIL rand_ack t=%0d lat=%0d if=%b d=%b want lat=%0d d=%b", t, lat, gi, gd, want_lat, want_d); else passed++;
            if (want_d && d_we) begin
                checks++; if (wr_log.size() != 1 || wr_log[0].a !== d_addr || wr_log[0].d !== d_wdata)
                    $display("FAIL rand_store t=%0d writes=%0d want addr=%h data=%h", t, wr_log.size(), d_addr, d_wdata); else passed++;
            end else begin
                checks++; if ((want_d ? d_rdata : if_rdata) !== want_data)
                    $display("FAIL rand_read t=%0d got=%h want=%h", t, want_d ? d_rdata : if_rdata, want_data); else passed++;
            end
            $display("txn rand t=%0d owner=%s we=%b lat=%0d data=%h", t, want_d ? "D" : "IF", want_d && d_we, lat, want_data);
            if (want_d) begin d_p = 1'b0; d_req = 1'b0; end
            else        begin if_p = 1'b0; if_req = 1'b0; end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_kill = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_kill();
        test_reset_mid();
        test_starve();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
